// File: rtl/ifu_axi_fetch_if.sv
// Bundle between the fetch stage and its neighbours: PC redirect feedback, the
// stage handshake toward decode, and the AXI4-Lite master channels.
interface ifu_axi_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    redir_valid;
    logic [ADDR_WIDTH-1:0]   redir_target;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_pc;
    logic [DATA_WIDTH-1:0]   out_inst;
    logic                    out_fault;

    logic [ADDR_WIDTH-1:0]   m_araddr;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rvalid;
    logic                    m_rready;

    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic                    m_awvalid;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wvalid;
    logic                    m_bready;

    modport master (
        input  redir_valid, redir_target, out_ready,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        output out_valid, out_pc, out_inst, out_fault,
        output m_araddr, m_arvalid, m_rready,
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
    );

    modport slave (
        output redir_valid, redir_target, out_ready,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        input  out_valid, out_pc, out_inst, out_fault,
        input  m_araddr, m_arvalid, m_rready,
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
    );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch: one outstanding AXI4-Lite read, redirect with wrong-path drop.
// Define IFU_PERF_CNT_EN to add the fetch/stall performance counters.
module ifu_axi_fetch #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h8000_0000
) (
    input  logic clk,
    input  logic rst_n,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    ifu_axi_fetch_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StOut} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  fault_q, fault_d;

    logic ar_fire, r_fire, out_fire, redir;

    assign redir    = bus.redir_valid;
    assign ar_fire  = bus.m_arvalid & bus.m_arready;
    assign r_fire   = bus.m_rvalid & bus.m_rready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            araddr_q <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            araddr_q <= araddr_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        // Redirect always wins over the sequential pc+4 step.
        if (redir) pc_d = bus.redir_target;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                // Address already on the bus must complete; mark its response as wrong-path.
                if (redir)   drop_d  = 1'b1;
                if (ar_fire) state_d = StResp;
            end
            StResp: begin
                if (r_fire) begin
                    if (drop_q || redir) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        inst_d  = bus.m_rdata;
                        fault_d = (bus.m_rresp != 2'b00);
                        state_d = StOut;
                    end
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            StOut: begin
                if (redir) begin
                    state_d = StReq;
                end else if (out_fire) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture the request address only on entry so it stays stable while arready is low.
        araddr_d = araddr_q;
        if (state_d == StReq && state_q != StReq) araddr_d = pc_d;
    end

    assign bus.m_arvalid = (state_q == StReq);
    assign bus.m_araddr  = araddr_q;
    assign bus.m_rready  = (state_q == StResp);

    assign bus.out_valid = (state_q == StOut) & ~redir;
    assign bus.out_pc    = pc_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_fault = fault_q;

    assign bus.m_awaddr  = '0;
    assign bus.m_awvalid = 1'b0;
    assign bus.m_wdata   = '0;
    assign bus.m_wstrb   = '0;
    assign bus.m_wvalid  = 1'b0;
    assign bus.m_bready  = 1'b1;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_fire)                         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.out_valid && !bus.out_ready)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: AXI-Lite memory responder, architectural PC model with
// per-cycle output checks, and directed scenarios with literal expectations.
module tb_ifu_axi_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_axi_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ifu_axi_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [31:0] fault_addr = 32'h0000_0001;
    int          ar_delay   = 0;
    int          r_delay    = 0;

    logic [31:0] ar_log[$];
    int          ar_cyc[$];
    logic [31:0] fire_pc[$];
    logic [31:0] fire_inst[$];
    logic        fire_fault[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory image: the first four words hold NOPs, every other word is tagged by its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= RESET_PC && a < RESET_PC + 32'd16) return 32'h0000_0013;
        return {a[15:0], 16'h0013};
    endfunction

    // AXI-Lite read responder with programmable AR and R wait states.
    initial begin
        bit          pending = 0;
        bit          ar_f, r_f;
        logic [31:0] a_s, paddr;
        int          rcnt = 0;
        int          acnt = 0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 2'b00;
        paddr         = '0;
        forever begin
            @(negedge clk);
            ar_f = bus.m_arvalid && bus.m_arready;
            r_f  = bus.m_rvalid && bus.m_rready;
            a_s  = bus.m_araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pending       = 0;
                acnt          = 0;
                bus.m_rvalid  = 1'b0;
                bus.m_arready = 1'b0;
            end else begin
                if (r_f) begin
                    bus.m_rvalid = 1'b0;
                    pending      = 0;
                end
                if (ar_f) begin
                    pending = 1;
                    paddr   = a_s;
                    rcnt    = r_delay;
                    acnt    = 0;
                end
                if (pending && !bus.m_rvalid) begin
                    if (rcnt == 0) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = mem_word(paddr);
                        bus.m_rresp  = (paddr == fault_addr) ? 2'b10 : 2'b00;
                    end else begin
                        rcnt--;
                    end
                end
                if (bus.m_arvalid && !pending) begin
                    if (acnt >= ar_delay) bus.m_arready = 1'b1;
                    else begin
                        bus.m_arready = 1'b0;
                        acnt++;
                    end
                end else begin
                    bus.m_arready = 1'b0;
                end
            end
        end
    end

    // Architectural model: the next instruction decode must see is at exp_pc, with the
    // memory word and fault status of that address. Redirect replaces it, a fire adds 4.
    initial begin
        logic [31:0] exp_pc = RESET_PC;
        bit          outstanding = 0;
        bit          prev_stall = 0;
        bit          prev_ar_stall = 0;
        logic [31:0] prev_pc = '0, prev_inst = '0, prev_araddr = '0;
        logic        prev_fault = 1'b0;
        logic [31:0] m_fetch = '0, m_stall = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                check("rst_arvalid", bus.m_arvalid, 32'd0);
                check("rst_rready", bus.m_rready, 32'd0);
                check("rst_out_valid", bus.out_valid, 32'd0);
                check("rst_araddr", bus.m_araddr, RESET_PC);
`ifdef IFU_PERF_CNT_EN
                check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
                check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
                exp_pc = RESET_PC;
                outstanding = 0;
                prev_stall = 0;
                prev_ar_stall = 0;
                m_fetch = '0;
                m_stall = '0;
            end else begin
                if (bus.out_valid) begin
                    check("out_pc", bus.out_pc, exp_pc);
                    check("out_inst", bus.out_inst, mem_word(exp_pc));
                    check("out_fault", bus.out_fault, (exp_pc == fault_addr) ? 32'd1 : 32'd0);
                end
                if (bus.redir_valid) check("valid_masked_by_redir", bus.out_valid, 32'd0);
                if (prev_stall && !bus.redir_valid) begin
                    check("stall_valid_held", bus.out_valid, 32'd1);
                    check("stall_pc_stable", bus.out_pc, prev_pc);
                    check("stall_inst_stable", bus.out_inst, prev_inst);
                    check("stall_fault_stable", bus.out_fault, prev_fault);
                end
                if (prev_ar_stall) begin
                    check("ar_valid_held", bus.m_arvalid, 32'd1);
                    check("ar_addr_stable", bus.m_araddr, prev_araddr);
                end
`ifdef IFU_PERF_CNT_EN
                check("perf_fetch", perf_fetch_cnt, m_fetch);
                check("perf_stall", perf_stall_cnt, m_stall);
`endif
                if (bus.m_arvalid && bus.m_arready) begin
                    check("one_outstanding", outstanding, 32'd0);
                    outstanding = 1;
                    ar_log.push_back(bus.m_araddr);
                    ar_cyc.push_back(cycle);
                end
                if (bus.m_rvalid && bus.m_rready) outstanding = 0;
                if (bus.out_valid && bus.out_ready) begin
                    fire_pc.push_back(bus.out_pc);
                    fire_inst.push_back(bus.out_inst);
                    fire_fault.push_back(bus.out_fault);
                    m_fetch = m_fetch + 32'd1;
                end
                if (bus.out_valid && !bus.out_ready) m_stall = m_stall + 32'd1;

                prev_stall    = bus.out_valid && !bus.out_ready;
                prev_pc       = bus.out_pc;
                prev_inst     = bus.out_inst;
                prev_fault    = bus.out_fault;
                prev_ar_stall = bus.m_arvalid && !bus.m_arready;
                prev_araddr   = bus.m_araddr;

                if (bus.redir_valid)                      exp_pc = bus.redir_target;
                else if (bus.out_valid && bus.out_ready)  exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic wait_fires(input int n);
        int k = 0;
        while (fire_pc.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (fire_pc.size() < n) check("wait_fires_timeout", fire_pc.size(), n);
    endtask

    task automatic wait_ar(input logic [31:0] a);
        int k = 0;
        while (!(bus.m_arvalid && bus.m_arready && bus.m_araddr == a) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("wait_ar_timeout", bus.m_araddr, a);
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int fb, ab, k;
        bus.redir_valid  = 1'b0;
        bus.redir_target = '0;
        bus.out_ready    = 1'b1;

        // Reset values and the sequential zero-wait stream.
        @(negedge clk);
        check("A_rst_arvalid", bus.m_arvalid, 32'd0);
        check("A_rst_rready", bus.m_rready, 32'd0);
        check("A_rst_out_valid", bus.out_valid, 32'd0);
        check("A_rst_out_fault", bus.out_fault, 32'd0);
        check("A_rst_out_inst", bus.out_inst, 32'd0);
        check("A_rst_araddr", bus.m_araddr, 32'h8000_0000);
        leave_reset();
        wait_fires(3);
        check("A_first_araddr", ar_log[0], 32'h8000_0000);
        check("A_pc0", fire_pc[0], 32'h8000_0000);
        check("A_pc1", fire_pc[1], 32'h8000_0004);
        check("A_pc2", fire_pc[2], 32'h8000_0008);
        check("A_inst0", fire_inst[0], 32'h0000_0013);
        check("A_inst2", fire_inst[2], 32'h0000_0013);
        check("A_fault1", fire_fault[1], 32'd0);
        check("A_issue_period", ar_cyc[1] - ar_cyc[0], 32'd3);

        // Five-cycle decode stall, then a single fire.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!(bus.out_valid && !bus.out_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("B_stall_seen", bus.out_valid, 32'd1);
        repeat (4) @(negedge clk);
        check("B_stall_pc", bus.out_pc, 32'h8000_000C);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        fb = fire_pc.size();
        @(negedge clk);
        check("B_fire_valid", bus.out_valid, 32'd1);
        @(negedge clk);
`ifdef IFU_PERF_CNT_EN
        check("B_perf_stall_5", perf_stall_cnt, 32'd5);
        check("B_perf_fetch_4", perf_fetch_cnt, 32'd4);
`endif
        wait_fires(fb + 1);
        check("B_fired_pc", fire_pc[fb], 32'h8000_000C);
        wait_fires(fb + 2);
        check("B_next_pc", fire_pc[fb + 1], 32'h8000_0010);

        // Redirect one cycle after AR for 8000_0004 while R is delayed.
        enter_reset();
        r_delay = 3;
        fb = fire_pc.size();
        ab = ar_log.size();
        leave_reset();
        wait_ar(32'h8000_0004);
        @(posedge clk);
        #1;
        bus.redir_valid  = 1'b1;
        bus.redir_target = 32'h8000_0100;
        @(posedge clk);
        #1;
        bus.redir_valid = 1'b0;
        wait_fires(fb + 2);
        check("C_pc0", fire_pc[fb], 32'h8000_0000);
        check("C_pc_target", fire_pc[fb + 1], 32'h8000_0100);
        check("C_inst_target", fire_inst[fb + 1], 32'h0100_0013);
        check("C_ar_target", ar_log[ab + 2], 32'h8000_0100);
        r_delay = 0;

        // Redirect while AR is stalled: old address holds until accepted.
        enter_reset();
        ar_delay = 3;
        fb = fire_pc.size();
        ab = ar_log.size();
        leave_reset();
        k = 0;
        while (!(bus.m_arvalid && !bus.m_arready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        bus.redir_valid  = 1'b1;
        bus.redir_target = 32'h8000_0200;
        @(negedge clk);
        check("D_arready_low", bus.m_arready, 32'd0);
        check("D_araddr_held", bus.m_araddr, 32'h8000_0000);
        @(posedge clk);
        #1;
        bus.redir_valid = 1'b0;
        wait_fires(fb + 1);
        check("D_ar_old", ar_log[ab], 32'h8000_0000);
        check("D_ar_target", ar_log[ab + 1], 32'h8000_0200);
        check("D_pc_target", fire_pc[fb], 32'h8000_0200);
        ar_delay = 0;

        // SLVERR at 8000_0008 is reported in the payload only.
        enter_reset();
        fault_addr = 32'h8000_0008;
        fb = fire_pc.size();
        leave_reset();
        wait_fires(fb + 4);
        check("E_pc_fault", fire_pc[fb + 2], 32'h8000_0008);
        check("E_fault_set", fire_fault[fb + 2], 32'd1);
        check("E_fault_prev", fire_fault[fb + 1], 32'd0);
        check("E_pc_next", fire_pc[fb + 3], 32'h8000_000C);
        check("E_fault_next", fire_fault[fb + 3], 32'd0);

        // Redirect while holding an instruction with decode ready.
        enter_reset();
        fault_addr = 32'h0000_0001;
        bus.out_ready = 1'b0;
        fb = fire_pc.size();
        leave_reset();
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        bus.out_ready    = 1'b1;
        bus.redir_valid  = 1'b1;
        bus.redir_target = 32'h8000_0300;
        @(negedge clk);
        check("F_no_valid_on_redir", bus.out_valid, 32'd0);
        @(posedge clk);
        #1;
        bus.redir_valid = 1'b0;
        wait_fires(fb + 1);
        check("F_pc_target", fire_pc[fb], 32'h8000_0300);
        check("F_inst_target", fire_inst[fb], 32'h0300_0013);

        // Back-to-back redirects: the last target wins.
        @(posedge clk);
        #1;
        fb = fire_pc.size();
        bus.redir_valid  = 1'b1;
        bus.redir_target = 32'h8000_0400;
        @(posedge clk);
        #1;
        bus.redir_target = 32'h8000_0500;
        @(posedge clk);
        #1;
        bus.redir_valid = 1'b0;
        wait_fires(fb + 1);
        check("G_last_target", fire_pc[fb], 32'h8000_0500);

        @(negedge clk);
        check("tie_awvalid", bus.m_awvalid, 32'd0);
        check("tie_wvalid", bus.m_wvalid, 32'd0);
        check("tie_bready", bus.m_bready, 32'd1);
        check("tie_awaddr", bus.m_awaddr, 32'd0);
        check("tie_wdata", bus.m_wdata, 32'd0);
        check("tie_wstrb", bus.m_wstrb, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
